// File: rtl/axis_tx_rr_arbiter.sv
// Packet-granular 2:1 round-robin arbiter sharing one AXIS TX path between two sources.
// Grant is held from the first beat through the accepted tlast beat; no data is buffered.
module axis_tx_rr_arbiter #(
  parameter int P_DATA_W = 64,
  parameter int P_USER_W = 32,
  parameter int P_CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_ch_en,
  input  logic [P_DATA_W-1:0]   s0_axis_tdata,
  input  logic [P_DATA_W/8-1:0] s0_axis_tkeep,
  input  logic [P_USER_W-1:0]   s0_axis_tuser,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [P_DATA_W-1:0]   s1_axis_tdata,
  input  logic [P_DATA_W/8-1:0] s1_axis_tkeep,
  input  logic [P_USER_W-1:0]   s1_axis_tuser,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [P_DATA_W-1:0]   m_axis_tdata,
  output logic [P_DATA_W/8-1:0] m_axis_tkeep,
  output logic [P_USER_W-1:0]   m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [1:0]            o_grant,
  output logic [P_CNT_W-1:0]    o_pkt_cnt0,
  output logic [P_CNT_W-1:0]    o_pkt_cnt1
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_e;

  state_e               state_q, state_d;
  logic                 r_last_q, r_last_d;
  logic [1:0]           grant_q, grant_d;
  logic [P_CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [P_CNT_W-1:0]   cnt1_q, cnt1_d;
  logic                 req0, req1, last_acc;

  assign req0 = s0_axis_tvalid & i_ch_en[0];
  assign req1 = s1_axis_tvalid & i_ch_en[1];

  // Datapath mux: zero latency, outputs forced to 0 while idle.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tuser   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      GNT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tuser   = s0_axis_tuser;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tvalid  = s0_axis_tvalid;
        s0_axis_tready = m_axis_tready;
      end
      GNT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tvalid  = s1_axis_tvalid;
        s1_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign last_acc = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
    state_d  = state_q;
    r_last_d = r_last_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    case (state_q)
      IDLE: begin
        // On contention the channel that did not finish last wins.
        if (req0 && req1)  state_d = r_last_q ? GNT0 : GNT1;
        else if (req0)     state_d = GNT0;
        else if (req1)     state_d = GNT1;
      end
      GNT0: if (last_acc) begin
        state_d  = IDLE;
        r_last_d = 1'b0;
        cnt0_d   = cnt0_q + P_CNT_W'(1);
      end
      GNT1: if (last_acc) begin
        state_d  = IDLE;
        r_last_d = 1'b1;
        cnt1_d   = cnt1_q + P_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == GNT1, state_d == GNT0};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      r_last_q <= 1'b1;
      grant_q  <= 2'b00;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      r_last_q <= r_last_d;
      grant_q  <= grant_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_pkt_cnt0 = cnt0_q;
  assign o_pkt_cnt1 = cnt1_q;

endmodule
